display_scan_7seg: RTL and testbench

//   Multiplexed 4-digit common-anode 7-segment scanner, driven by the 1-cycle refresh strobe

---
 rtl/display_scan_7seg.sv | 151 +++++++++++++++
 tb/tb_display_scan_7seg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_7seg.sv
// rtl/display_scan_7seg.sv - multiplexed N-digit 7-segment scanner with dead-time and frame-synchronous data swap
// Staging captures on i_Load; shadow (what is scanned) updates only at frame boundaries.
module display_scan_7seg #(
  parameter int N_DIG    = 4,
  parameter int DEAD_CYC = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Tick,
  input  logic               i_Load,
  input  logic [4*N_DIG-1:0] i_Data,
  input  logic [N_DIG-1:0]   i_Dp,
  input  logic               i_Blank_Lz,
  output logic [N_DIG-1:0]   o_Anode,
  output logic [6:0]         o_Seg,
  output logic               o_Dp,
  output logic               o_Frame
);

  localparam int IDX_W = $clog2(N_DIG);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         dead_q;
  logic [4*N_DIG-1:0] stage_data_q;
  logic [N_DIG-1:0]   stage_dp_q;
  logic [4*N_DIG-1:0] shadow_data_q;
  logic [N_DIG-1:0]   shadow_dp_q;
  logic               pend_q;

  logic [3:0]         digit_d;
  logic [N_DIG:0]     zero_up_d;
  logic               lz_blank_d;
  logic [6:0]         seg_d;
  logic [N_DIG-1:0]   anode_d;
  logic               dp_d;
  logic [IDX_W-1:0]   idx_next_d;
  logic               last_d;
  logic               boundary_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // zero_up_d[k] is set when digit k and every digit above it are zero
  always_comb begin
    zero_up_d = '0;
    zero_up_d[N_DIG] = 1'b1;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      zero_up_d[k] = zero_up_d[k+1] & (shadow_data_q[4*k +: 4] == 4'd0);
    end
  end

  always_comb begin
    digit_d    = shadow_data_q[{idx_q, 2'b00} +: 4];
    lz_blank_d = i_Blank_Lz && (idx_q != '0) && zero_up_d[idx_q];
    seg_d      = lz_blank_d ? 7'h7F : hex_to_seg(digit_d);
    anode_d    = ~(N_DIG'(1) << idx_q);
    dp_d       = ~shadow_dp_q[idx_q];
    last_d     = (idx_q == IDX_W'(N_DIG - 1));
    idx_next_d = last_d ? '0 : idx_q + 1'b1;
    boundary_d = i_Tick && ((state_q == IDLE) || ((state_q == DRIVE) && last_d));
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      dead_q        <= '0;
      stage_data_q  <= '0;
      stage_dp_q    <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pend_q        <= 1'b0;
      o_Anode       <= '1;
      o_Seg         <= 7'h7F;
      o_Dp          <= 1'b1;
      o_Frame       <= 1'b0;
    end else begin
      o_Anode <= '1;
      o_Seg   <= 7'h7F;
      o_Dp    <= 1'b1;
      o_Frame <= boundary_d;

      // A boundary copies the staging value that existed before this edge
      if (boundary_d && pend_q) begin
        shadow_data_q <= stage_data_q;
        shadow_dp_q   <= stage_dp_q;
      end
      if (i_Load) begin
        stage_data_q <= i_Data;
        stage_dp_q   <= i_Dp;
        pend_q       <= 1'b1;
      end else if (boundary_d) begin
        pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (i_Tick) begin
            state_q <= BLANK;
            idx_q   <= '0;
            dead_q  <= 8'(DEAD_CYC - 1);
          end
        end
        BLANK: begin
          if (dead_q == 8'd0) begin
            state_q <= DRIVE;
            o_Anode <= anode_d;
            o_Seg   <= seg_d;
            o_Dp    <= dp_d;
          end else begin
            dead_q <= dead_q - 8'd1;
          end
        end
        DRIVE: begin
          if (i_Tick) begin
            state_q <= BLANK;
            idx_q   <= idx_next_d;
            dead_q  <= 8'(DEAD_CYC - 1);
          end else begin
            o_Anode <= anode_d;
            o_Seg   <= seg_d;
            o_Dp    <= dp_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_7seg.sv
// tb/tb_display_scan_7seg.sv - self-checking bench for display_scan_7seg
// Cycle model plus directed literal checks of the scan sequence.
module tb_display_scan_7seg;

  localparam int N_DIG = 4;
  localparam int DEAD  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        blz = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_out;
  logic        frame;

  int checks = 0;
  int errors = 0;

  display_scan_7seg #(.N_DIG(N_DIG), .DEAD_CYC(DEAD)) dut (
    .i_Clk(clk), .i_Reset(rst_n), .i_Tick(tick), .i_Load(load),
    .i_Data(data), .i_Dp(dp_in), .i_Blank_Lz(blz),
    .o_Anode(anode), .o_Seg(seg), .o_Dp(dp_out), .o_Frame(frame)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model: phase 0 idle, 1 dark gap, 2 showing digit m_dig
  int          m_phase = 0;
  int          m_left = 0;
  int          m_dig = 0;
  logic [15:0] m_stage = '0, m_shadow = '0;
  logic [3:0]  m_stage_dp = '0, m_shadow_dp = '0;
  bit          m_pend = 0, m_frame = 0, m_blz = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_dig = 0; m_stage = '0; m_shadow = '0;
      m_stage_dp = '0; m_shadow_dp = '0; m_pend = 0; m_frame = 0; m_blz = 0;
    end else begin
      m_frame = tick && (m_phase == 0 || (m_phase == 2 && m_dig == N_DIG - 1));
      if (m_frame && m_pend) begin
        m_shadow = m_stage; m_shadow_dp = m_stage_dp; m_pend = 0;
      end
      if (load) begin
        m_stage = data; m_stage_dp = dp_in; m_pend = 1;
      end
      m_blz = blz;
      if (m_phase == 0 && tick) begin
        m_phase = 1; m_left = DEAD; m_dig = 0;
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end else if (m_phase == 2 && tick) begin
        m_phase = 1; m_left = DEAD; m_dig = (m_dig + 1) % N_DIG;
      end
    end
  end

  always @(posedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         upper;
    #3;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (rst_n && m_phase == 2) begin
      upper = int'(m_shadow) >> (4 * m_dig);
      e_an  = ~(4'b0001 << m_dig);
      e_seg = (m_blz && m_dig > 0 && upper == 0) ? 7'h7F : seg_tab[upper & 15];
      e_dp  = ~m_shadow_dp[m_dig];
    end
    check("model", {anode, seg, dp_out, frame}, {e_an, e_seg, e_dp, rst_n ? m_frame : 1'b0});
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    load = 1'b1; data = d; dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic tick_step(input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp,
                           input logic e_fr, input bit glitch, input bit ld,
                           input logic [15:0] ld_d);
    @(negedge clk);
    tick = 1'b1;
    if (ld) begin load = 1'b1; data = ld_d; dp_in = 4'b0000; end
    for (int i = 1; i <= DEAD; i++) begin
      @(posedge clk); #3;
      if (i == 1) begin
        tick = 1'b0; load = 1'b0;
        check("frame", frame, e_fr);
      end
      if (glitch && i == 4) tick = 1'b1;
      if (glitch && i == 5) tick = 1'b0;
      check("gap_anode", anode, 4'hF);
    end
    @(posedge clk); #3;
    check("anode", anode, e_an);
    check("seg", seg, e_seg);
    check("dp", dp_out, e_dp);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); tick = ~tick;
      @(posedge clk); #3;
      check("rst_outs", {anode, seg, dp_out, frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    @(negedge clk); tick = 1'b0; rst_n = 1'b1;

    do_load(16'h1234, 4'b0100);
    tick_step(4'hE, 7'h19, 1'b1, 1'b1, 0, 0, 16'h0);
    tick_step(4'hD, 7'h30, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hB, 7'h24, 1'b0, 1'b0, 0, 0, 16'h0);
    tick_step(4'h7, 7'h79, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hE, 7'h19, 1'b1, 1'b1, 0, 0, 16'h0);
    tick_step(4'hD, 7'h30, 1'b1, 1'b0, 1, 0, 16'h0);

    do_load(16'h5678, 4'b0000);
    tick_step(4'hB, 7'h24, 1'b0, 1'b0, 0, 0, 16'h0);
    tick_step(4'h7, 7'h79, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hE, 7'h00, 1'b1, 1'b1, 0, 0, 16'h0);

    @(negedge clk); blz = 1'b1;
    do_load(16'h0045, 4'b0000);
    tick_step(4'hD, 7'h78, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hB, 7'h02, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'h7, 7'h12, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hE, 7'h12, 1'b1, 1'b1, 0, 0, 16'h0);
    tick_step(4'hD, 7'h19, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hB, 7'h7F, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'h7, 7'h7F, 1'b1, 1'b0, 0, 0, 16'h0);
    do_load(16'h0000, 4'b0000);
    tick_step(4'hE, 7'h40, 1'b1, 1'b1, 0, 1, 16'hABCD);
    tick_step(4'hD, 7'h7F, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hB, 7'h7F, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'h7, 7'h7F, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hE, 7'h21, 1'b1, 1'b1, 0, 0, 16'h0);
    tick_step(4'hD, 7'h46, 1'b1, 1'b0, 0, 0, 16'h0);
    tick_step(4'hB, 7'h03, 1'b1, 1'b0, 0, 0, 16'h0);

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #3;
    check("rst_mid", {anode, seg, dp_out, frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    tick_step(4'hE, 7'h40, 1'b1, 1'b1, 0, 0, 16'h0);
    repeat (4) @(posedge clk);

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
